// File: rtl/prg_loader.sv
// Packs instruction fields into 16-bit PRG words and writes them sequentially
// into program memory from a loadable base address.
module prg_loader #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_ins,
  input  logic [4:0]    in_g1,
  input  logic [3:0]    in_fnc,
  input  logic [4:0]    in_g2,
  input  logic [7:0]    in_cns,
  input  logic          in_last,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_wdata,
  output logic          busy,
  output logic          done,
  output logic          err_full,
  output logic [AW:0]   count
);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          err_q, err_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [15:0]   prg_word;
  logic          xfer;
  logic          at_top;

  // Register form carries fnc/g2; constant form carries a zero pad bit and cns.
  always_comb begin
    if (!in_ins[1]) prg_word = {in_ins, in_g1, in_fnc, in_g2};
    else            prg_word = {in_ins, in_g1, 1'b0, in_cns};
  end

  always_comb begin
    xfer   = in_valid && in_ready;
    at_top = &ptr_q;
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values together.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = LOAD;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        LOAD:    if (xfer && (in_last || at_top)) state_d = FLUSH;
        FLUSH:   state_d = err_q ? IDLE : DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready = (state_q == LOAD) && !err_q;
    busy     = (state_q == LOAD) || (state_q == FLUSH);
    done     = (state_q == DONE);
  end

  // start wins over a same-cycle transfer, discarding it.
  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    err_d   = err_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (start) begin
      ptr_d   = base;
      count_d = '0;
      err_d   = 1'b0;
    end else if (xfer) begin
      we_d    = 1'b1;
      addr_d  = ptr_q;
      wdata_d = prg_word;
      ptr_d   = ptr_q + 1'b1;
      count_d = count_q + 1'b1;
      if (at_top && !in_last) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    mem_we    = we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    err_full  = err_q;
    count     = count_q;
  end

endmodule

// File: doc/prg_loader.md
Name: prg_loader

Overview:
- Encoder and writer for the 16-bit program word format that the instruction decoder unpacks.
- Accepts instruction fields over a valid/ready handshake and packs them into a PRG word.
- Writes the words sequentially into program memory, starting at a loadable base address.
- Sits between the host/boot interface and the program RAM. Tracks word count, completion and address overflow.

Parameters:
- AW, 8, program memory address width; depth is 2**AW words.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset.
- start  input  1  single-cycle pulse; begins a load session at base.
- base  input  AW  first write address, sampled when start=1.
- in_valid  input  1  instruction fields valid.
- in_ready  output  1  loader accepts fields this cycle.
- in_ins  input  2  instruction class, PRG[15:14].
- in_g1  input  5  destination register field.
- in_fnc  input  4  function field (register form only).
- in_g2  input  5  source register field (register form only).
- in_cns  input  8  constant field (constant form only).
- in_last  input  1  marks the final instruction of the session.
- mem_we  output  1  program memory write strobe.
- mem_addr  output  AW  write address.
- mem_wdata  output  16  encoded PRG word.
- busy  output  1  session active (LOAD or FLUSH).
- done  output  1  one-cycle pulse after the last word is written.
- err_full  output  1  sticky; the address space was exhausted.
- count  output  AW+1  words written in the current session.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst. All flops update on the rising edge of clk.
- Reset values: state=IDLE, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err_full=0, count=0, in_ready=0.

Encoding (combinational, registered on accept):
- in_ins[1]=0 (register form): PRG = {in_ins, in_g1, in_fnc, in_g2}.
- in_ins[1]=1 (constant form): PRG = {in_ins, in_g1, 1'b0, in_cns}.
- Unused fields are ignored. Decoding the resulting PRG word returns the supplied fields exactly.

Handshake:
- in_ready = (state==LOAD) and not err_full. It is combinational from state only, never from in_valid.
- A transfer occurs when in_valid and in_ready are both 1.
- Latency is 1: a word accepted in cycle N appears in cycle N+1 with mem_we=1, mem_addr=current pointer, mem_wdata=encoded word.
- mem_we=0 in every cycle without a preceding transfer. Throughput is one word per cycle.

Pointer and count:
- ptr (AW bits) loads base on start and increments by 1 on each write.
- count increments by 1 on each write and clears on start.
- Overflow: if a write occurs at ptr = 2**AW-1 and the word is not last, err_full becomes 1 in the same cycle as that write.
- On overflow the state goes to FLUSH, ptr wraps to 0 but no further writes occur, and done is not pulsed.
- err_full clears only on start or rst.

State machine:
- IDLE: start -> LOAD.
- LOAD: a transfer with in_last=1 -> FLUSH. Overflow also -> FLUSH.
- FLUSH: the final write occurs in this cycle. Next state is DONE if no error, otherwise IDLE.
- DONE: done=1 for exactly one cycle -> IDLE.
- busy=1 in LOAD and FLUSH.

Priority and boundary cases:
- start has priority in every state, including mid-session. The next cycle is LOAD with ptr=base, count=0, err_full=0.
- Any pending write registered in the start cycle is dropped (mem_we=0 in the following cycle).
- rst mid-session returns all outputs to reset values; no write is issued.
- start in the same cycle as a transfer discards that transfer.
- in_last on the first word of a session is legal: count=1, then done.
- in_valid while not LOAD is ignored and has no side effects.

Test Plan:
- rst, start base=0x10, three transfers back-to-back: (ins=00,g1=2,fnc=5,g2=4), (ins=10,g1=3,cns=0xA5), (ins=11,g1=0,cns=0x7F,last=1). Required: writes at 0x10/0x11/0x12 with data 0x04A4/0x86A5/0xC07F on consecutive cycles; done pulses 2 cycles after the last accept; count=3.
- in_valid toggling 1,0,1,0 with one-word gaps: mem_we follows each accept by exactly one cycle; addresses stay contiguous; no duplicate writes.
- AW=8, base=0xFE, three non-last words: writes at 0xFE and 0xFF; err_full=1 with the 0xFF write; third word never accepted (in_ready=0); done never pulses; count=2.
- start asserted mid-session after 2 writes, base=0x40: pending write dropped; next accepted word written to 0x40; count restarts at 1; err_full cleared.
- rst asserted in the cycle after an accept: no mem_we; all outputs at reset values next cycle; in_ready=0 until a new start.
- Single-word session with in_last=1: one write at base; done=1 for exactly one cycle; busy deasserted in the DONE cycle.
